fft_bitrev_buf: RTL and testbench

Natural-order reorder buffer for the radix-2^2 SDF FFT output stream. It accepts the FFT's continuous bit-reversed output (`sync`, bin index, re/im) and writes each N-sample frame into one half of a ping-pong RAM. It simultaneously reads the previously completed frame out in natural bin order (0..N-1). It sits directly after the FFT core, on the same clock, and feeds downstream spectral consumers that require ascending bin order.

---
 rtl/fft_bitrev_buf.sv | 192 +++++++++++++++++++
 tb/tb_fft_bitrev_buf.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fft_bitrev_buf.sv
`default_nettype none
// ============================================================================
//  Module   : fft_bitrev_buf
//  Purpose  : Natural-order reorder buffer for a radix-2^2 SDF FFT output.
//             Bit-reversed input frames are written into one half of a
//             ping-pong RAM while the previous complete frame is read out
//             in ascending bin order (0..N-1).
//  Ports    : clk_i, rst_i          - clock, synchronous active-high reset
//             sync_i, ctr_i         - input valid and bin index of sample
//             re_i, im_i            - input sample (signed)
//             valid_o, ctr_o        - output valid and natural bin index
//             re_o, im_o            - output sample (signed, bit-exact)
//             last_o                - marks bin N-1 on the output
//             frame_err_o           - 1-cycle pulse: partial frame dropped
//             ctr_err_o             - 1-cycle pulse: unexpected input bin
//  Revision : 1.0 - initial release
// ============================================================================
module fft_bitrev_buf #(
  parameter int N          = 1024,
  parameter int N_LOG2     = 10,
  parameter int DATA_WIDTH = 25
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         sync_i,
  input  logic [N_LOG2-1:0]            ctr_i,
  input  logic signed [DATA_WIDTH-1:0] re_i,
  input  logic signed [DATA_WIDTH-1:0] im_i,
  output logic                         valid_o,
  output logic [N_LOG2-1:0]            ctr_o,
  output logic signed [DATA_WIDTH-1:0] re_o,
  output logic signed [DATA_WIDTH-1:0] im_o,
  output logic                         last_o,
  output logic                         frame_err_o,
  output logic                         ctr_err_o
);

  localparam int                c_WORD_W   = 2 * DATA_WIDTH;
  localparam int                c_DEPTH    = 2 * N;
  localparam logic [N_LOG2-1:0] c_LAST_BIN = N_LOG2'(N - 1);
  localparam logic [N_LOG2-1:0] c_ONE      = N_LOG2'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_READ = 1'b1
  } rd_state_t;

  function automatic logic [N_LOG2-1:0] f_bitrev(input logic [N_LOG2-1:0] x);
    logic [N_LOG2-1:0] y;
    for (int i = 0; i < N_LOG2; i++) begin
      y[i] = x[N_LOG2-1-i];
    end
    return y;
  endfunction

  // --------------------------------------------------------------------------
  // Write side
  // --------------------------------------------------------------------------
  logic [N_LOG2-1:0] r_wr_cnt;
  logic              r_wr_bank;
  logic              r_frame_err;
  logic              r_ctr_err;
  logic              w_frame_done;

  // The N-th sample of a frame is being written on this edge.
  assign w_frame_done = sync_i && (r_wr_cnt == c_LAST_BIN);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_cnt    <= '0;
      r_wr_bank   <= 1'b0;
      r_frame_err <= 1'b0;
      r_ctr_err   <= 1'b0;
    end else begin
      r_ctr_err   <= sync_i && (ctr_i != f_bitrev(r_wr_cnt));
      // Pulse lasts one cycle because the counter is cleared on the same edge.
      r_frame_err <= !sync_i && (r_wr_cnt != '0);
      if (sync_i) begin
        // Counter width is exactly log2(N), so N-1 wraps naturally to 0.
        r_wr_cnt <= r_wr_cnt + c_ONE;
        if (w_frame_done) begin
          r_wr_bank <= ~r_wr_bank;
        end
      end else begin
        r_wr_cnt <= '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Ping-pong RAM: simple dual port, registered read, never cleared
  // --------------------------------------------------------------------------
  logic [c_WORD_W-1:0] r_mem [c_DEPTH];
  logic [c_WORD_W-1:0] r_rd_data;
  logic [N_LOG2-1:0]   r_rd_addr;
  logic                r_rd_bank;

  always_ff @(posedge clk_i) begin
    if (sync_i && !rst_i) begin
      // Written at the reported bin even when it mismatches the expected one.
      r_mem[{r_wr_bank, ctr_i}] <= {re_i, im_i};
    end
  end

  always_ff @(posedge clk_i) begin
    r_rd_data <= r_mem[{r_rd_bank, r_rd_addr}];
  end

  // --------------------------------------------------------------------------
  // Read-side state machine
  // --------------------------------------------------------------------------
  rd_state_t         r_state;
  rd_state_t         w_state_nxt;
  logic [N_LOG2-1:0] w_rd_addr_nxt;
  logic              w_rd_bank_nxt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_rd_addr <= '0;
      r_rd_bank <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rd_addr <= w_rd_addr_nxt;
      r_rd_bank <= w_rd_bank_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_rd_addr_nxt = r_rd_addr;
    w_rd_bank_nxt = r_rd_bank;
    if (w_frame_done) begin
      // With continuous input this coincides with the final read address,
      // so the next frame follows without a gap. The completed bank is the
      // one currently being written.
      w_state_nxt   = S_READ;
      w_rd_addr_nxt = '0;
      w_rd_bank_nxt = r_wr_bank;
    end else if (r_state == S_READ) begin
      if (r_rd_addr == c_LAST_BIN) begin
        w_state_nxt = S_IDLE;
      end else begin
        w_rd_addr_nxt = r_rd_addr + c_ONE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read pipeline: address stage aligned with the RAM's registered output,
  // then the output register.
  // --------------------------------------------------------------------------
  logic              r_pipe_vld;
  logic [N_LOG2-1:0] r_pipe_addr;
  logic              r_valid;
  logic              r_last;
  logic [N_LOG2-1:0] r_ctr;
  logic [DATA_WIDTH-1:0] r_re;
  logic [DATA_WIDTH-1:0] r_im;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pipe_vld  <= 1'b0;
      r_pipe_addr <= '0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_ctr       <= '0;
      r_re        <= '0;
      r_im        <= '0;
    end else begin
      r_pipe_vld  <= (r_state == S_READ);
      r_pipe_addr <= r_rd_addr;
      r_valid     <= r_pipe_vld;
      r_last      <= r_pipe_vld && (r_pipe_addr == c_LAST_BIN);
      if (r_pipe_vld) begin
        r_ctr <= r_pipe_addr;
        r_re  <= r_rd_data[c_WORD_W-1:DATA_WIDTH];
        r_im  <= r_rd_data[DATA_WIDTH-1:0];
      end
    end
  end

  assign valid_o     = r_valid;
  assign last_o      = r_last;
  assign ctr_o       = r_ctr;
  assign re_o        = r_re;
  assign im_o        = r_im;
  assign frame_err_o = r_frame_err;
  assign ctr_err_o   = r_ctr_err;

endmodule
`default_nettype wire

// File: tb/tb_fft_bitrev_buf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fft_bitrev_buf
//  Purpose  : Self-checking bench for fft_bitrev_buf (N=16). A reference
//             model tracks a two-bank sample store and, whenever a frame
//             completes, schedules the natural-order output for the cycles
//             on which each bin must appear.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fft_bitrev_buf;

  localparam int N      = 16;
  localparam int N_LOG2 = 4;
  localparam int DW     = 25;
  localparam int c_MAXCYC = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic                 sync;
  logic [N_LOG2-1:0]    ctr;
  logic signed [DW-1:0] re;
  logic signed [DW-1:0] im;
  logic                 valid_o;
  logic [N_LOG2-1:0]    ctr_o;
  logic signed [DW-1:0] re_o;
  logic signed [DW-1:0] im_o;
  logic                 last_o;
  logic                 frame_err_o;
  logic                 ctr_err_o;

  fft_bitrev_buf #(.N(N), .N_LOG2(N_LOG2), .DATA_WIDTH(DW)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .sync_i     (sync),
    .ctr_i      (ctr),
    .re_i       (re),
    .im_i       (im),
    .valid_o    (valid_o),
    .ctr_o      (ctr_o),
    .re_o       (re_o),
    .im_o       (im_o),
    .last_o     (last_o),
    .frame_err_o(frame_err_o),
    .ctr_err_o  (ctr_err_o)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model state
  int              m_cnt  = 0;
  int              m_bank = 0;
  logic [2*DW-1:0] m_mem   [2*N];
  bit              m_known [2*N];
  // Expected outputs indexed by the edge after which they must be visible
  bit              e_vld   [c_MAXCYC];
  int              e_bin   [c_MAXCYC];
  logic [2*DW-1:0] e_data  [c_MAXCYC];
  bit              e_dknown[c_MAXCYC];
  bit              e_ferr  [c_MAXCYC];
  bit              e_cerr  [c_MAXCYC];
  bit              e_rst   [c_MAXCYC];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int bitrev(input int x);
    int r = 0;
    for (int i = 0; i < N_LOG2; i++) begin
      if (((x >> i) & 1) != 0) r = r + (1 << (N_LOG2 - 1 - i));
    end
    return r;
  endfunction

  task automatic check_outputs();
    chk("valid", valid_o, e_vld[cyc]);
    chk("last", last_o, e_vld[cyc] && (e_bin[cyc] == N - 1));
    chk("frame_err", frame_err_o, e_ferr[cyc]);
    chk("ctr_err", ctr_err_o, e_cerr[cyc]);
    if (e_vld[cyc]) begin
      chk("ctr_o", {ctr_o}, e_bin[cyc]);
      if (e_dknown[cyc]) begin
        chk("re_o", {re_o}, e_data[cyc][2*DW-1:DW]);
        chk("im_o", {im_o}, e_data[cyc][DW-1:0]);
      end
    end
    if (e_rst[cyc]) begin
      chk("rst_ctr_o", {ctr_o}, 0);
      chk("rst_re_o", {re_o}, 0);
      chk("rst_im_o", {im_o}, 0);
    end
  endtask

  // Apply one cycle of input, advance the model, then check after the edge.
  task automatic tick(input bit r, input bit s, input int c, input int d_re, input int d_im);
    int e;
    int idx;
    rst  = r;
    sync = s;
    ctr  = c[N_LOG2-1:0];
    re   = d_re[DW-1:0];
    im   = d_im[DW-1:0];
    e    = cyc + 1;
    if (r) begin
      m_cnt  = 0;
      m_bank = 0;
      for (int k = e; k < c_MAXCYC; k++) e_vld[k] = 1'b0;
      e_rst[e]  = 1'b1;
      e_ferr[e] = 1'b0;
      e_cerr[e] = 1'b0;
    end else begin
      e_cerr[e] = s && (c != bitrev(m_cnt));
      e_ferr[e] = !s && (m_cnt != 0);
      if (s) begin
        idx          = m_bank * N + c;
        m_mem[idx]   = {re, im};
        m_known[idx] = 1'b1;
        if (m_cnt == N - 1) begin
          for (int k = 0; k < N; k++) begin
            if (e + 2 + k < c_MAXCYC) begin
              e_vld[e+2+k]    = 1'b1;
              e_bin[e+2+k]    = k;
              e_data[e+2+k]   = m_mem[m_bank*N+k];
              e_dknown[e+2+k] = m_known[m_bank*N+k];
            end
          end
          m_bank = 1 - m_bank;
          m_cnt  = 0;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end else begin
        m_cnt = 0;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 0, 0, 0);
  endtask

  // corrupt_at < 0 sends a clean frame; otherwise that sample carries bin 0.
  task automatic send_frame(input int corrupt_at);
    for (int k = 0; k < N; k++) begin
      tick(1'b0, 1'b1, (k == corrupt_at) ? 0 : bitrev(k), int'($urandom), int'($urandom));
    end
  endtask

  initial begin
    // Reset held with sync high and random samples.
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, bitrev(i), int'($urandom), int'($urandom));

    // Reorder with recognisable pattern.
    for (int k = 0; k < N; k++) tick(1'b0, 1'b1, bitrev(k), bitrev(k), -bitrev(k));
    idle(N + 4);

    // Three back-to-back frames.
    send_frame(-1);
    send_frame(-1);
    send_frame(-1);
    idle(N + 4);

    // Aborted frame followed by a full frame.
    for (int k = 0; k < 5; k++) tick(1'b0, 1'b1, bitrev(k), int'($urandom), int'($urandom));
    idle(3);
    send_frame(-1);
    idle(N + 4);

    // Index mismatch on sample 7.
    send_frame(7);
    idle(N + 4);

    // Reset during readout at bin 6.
    send_frame(-1);
    begin
      int w = 0;
      while (!(valid_o && ctr_o == 6) && w < 4 * N) begin
        idle(1);
        w++;
      end
      chk("wait_ctr6", valid_o && (ctr_o == 6), 1);
    end
    tick(1'b1, 1'b0, 0, 0, 0);
    idle(2 * N);
    send_frame(-1);
    idle(N + 4);

    // Randomised mix of continuous, gapped, aborted and corrupted frames.
    for (int f = 0; f < 24; f++) begin
      case ($urandom_range(0, 3))
        0: send_frame(-1);
        1: begin
          send_frame(-1);
          idle($urandom_range(1, N + 3));
        end
        2: begin
          int len = $urandom_range(1, N - 1);
          for (int k = 0; k < len; k++) tick(1'b0, 1'b1, bitrev(k), int'($urandom), int'($urandom));
          idle($urandom_range(1, 3));
        end
        default: send_frame($urandom_range(1, N - 1));
      endcase
    end
    idle(N + 4);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
